// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame capture, parity/framing flags.
// Optional inactivity abort inside a frame is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TO_CYCLES  = 32767
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_idle,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_timeout_tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DPS  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_ps2c_q, f_ps2c_d;
  logic                  fall_edge_s;
  logic [1:0]            state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [9:0]            b_q, b_d;
  logic [7:0]            dout_q, dout_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  done_q, done_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tmo_q, tmo_d;
`else
  logic unused_to_s;
  assign unused_to_s = ^TO_CYCLES;
`endif

  // Filtered clock only moves once the whole window agrees, so short pulses vanish.
  always_comb begin
    filter_d = {ps2c, filter_q[FILTER_LEN-1:1]};
    if (&filter_d) begin
      f_ps2c_d = 1'b1;
    end else if (~|filter_d) begin
      f_ps2c_d = 1'b0;
    end else begin
      f_ps2c_d = f_ps2c_q;
    end
  end

  assign fall_edge_s = f_ps2c_q & ~f_ps2c_d;

  // Frame FSM: start bit in idle, then 10 shifts (8 data, parity, stop), then one load cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall_edge_s && rx_en && !ps2d) begin
          state_d = DPS;
          n_d     = 4'd9;
`ifdef PS2_RX_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DPS: begin
        if (fall_edge_s) begin
          b_d = {ps2d, b_q[9:1]};
`ifdef PS2_RX_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (n_q == 4'd0) begin
            state_d = LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else begin
`ifdef PS2_RX_TIMEOUT_EN
          if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = DPS;
`endif
        end
      end
      LOAD: begin
        dout_d  = b_q[7:0];
        perr_d  = ~odd_parity_ok(b_q[8:0]);
        ferr_d  = ~b_q[9];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
      state_q  <= IDLE;
      n_q      <= 4'd0;
      b_q      <= 10'd0;
      dout_q   <= 8'h00;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
      state_q  <= state_d;
      n_q      <= n_d;
      b_q      <= b_d;
      dout_q   <= dout_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      done_q   <= done_d;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign rx_idle      = (state_q == IDLE);
  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
`ifdef PS2_RX_TIMEOUT_EN
  assign rx_timeout_tick = tmo_q;
`else
  assign rx_timeout_tick = 1'b0;
`endif

endmodule
